// File: rtl/reg_file_ckpt.sv
// reg_file_ckpt: 1W/2R register file with fixed taps, optional write forwarding,
// a shadow bank for single-cycle save/restore/swap, and a per-register dirty map.
module reg_file_ckpt #(
   parameter int W      = 8,
   parameter int AW     = 3,
   parameter int BYPASS = 1,
   parameter int TAP_A  = 0,
   parameter int TAP_B  = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wr_en,
   input  logic [AW-1:0]     wr_addr,
   input  logic [W-1:0]      dat_in,
   input  logic [AW-1:0]     rd_addrA,
   input  logic [AW-1:0]     rd_addrB,
   input  logic              save,
   input  logic              restore,
   output logic [W-1:0]      datA_out,
   output logic [W-1:0]      datB_out,
   output logic [W-1:0]      tap_a_out,
   output logic [W-1:0]      tap_b_out,
   output logic [2**AW-1:0]  dirty,
   output logic              any_dirty
);
   localparam int N = 2**AW;
   localparam logic [AW-1:0] TA = AW'(TAP_A);
   localparam logic [AW-1:0] TB = AW'(TAP_B);
   logic [W-1:0] core_q [N];
   logic [W-1:0] core_d [N];
   logic [W-1:0] shad_q [N];
   logic [W-1:0] shad_d [N];
   logic [N-1:0] dirty_q, dirty_d;
   logic         fwd_ok, fwd_a, fwd_b;
   // shadow always captures pre-write core; restore (incl. swap) drops the write
   always_comb begin
      core_d  = core_q;
      shad_d  = shad_q;
      dirty_d = (save || restore) ? '0 : dirty_q;
      if (save) shad_d = core_q;
      if (restore) core_d = shad_q;
      else if (wr_en) begin
         core_d[wr_addr]  = dat_in;
         dirty_d[wr_addr] = 1'b1;
      end
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < N; i++) begin
            core_q[i] <= '0;
            shad_q[i] <= '0;
         end
         dirty_q <= '0;
      end else begin
         core_q  <= core_d;
         shad_q  <= shad_d;
         dirty_q <= dirty_d;
      end
   end
   assign fwd_ok    = (BYPASS != 0) && wr_en && !reset && !restore;
   assign fwd_a     = fwd_ok && (rd_addrA == wr_addr);
   assign fwd_b     = fwd_ok && (rd_addrB == wr_addr);
   assign datA_out  = fwd_a ? dat_in : core_q[rd_addrA];
   assign datB_out  = fwd_b ? dat_in : core_q[rd_addrB];
   assign tap_a_out = core_q[TA];
   assign tap_b_out = core_q[TB];
   assign dirty     = dirty_q;
   assign any_dirty = |dirty_q;
endmodule

// File: tb/tb_reg_file_ckpt.sv
// tb_reg_file_ckpt: directed checks of reg_file_ckpt, run on a BYPASS=1 and a BYPASS=0 instance.
module tb_reg_file_ckpt;
   logic       clk = 1'b0;
   logic       reset, wr_en, save, restore;
   logic [2:0] wr_addr, rd_addrA, rd_addrB;
   logic [7:0] dat_in;
   logic [7:0] a1, b1, ta1, tb1, d1, a0, b0, ta0, tb0, d0;
   logic       any1, any0;
   int         passed = 0, total = 0;

   always #5 clk = ~clk;

   reg_file_ckpt #(.BYPASS(1)) u1 (
      .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .dat_in(dat_in),
      .rd_addrA(rd_addrA), .rd_addrB(rd_addrB), .save(save), .restore(restore),
      .datA_out(a1), .datB_out(b1), .tap_a_out(ta1), .tap_b_out(tb1),
      .dirty(d1), .any_dirty(any1));
   reg_file_ckpt #(.BYPASS(0)) u0 (
      .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .dat_in(dat_in),
      .rd_addrA(rd_addrA), .rd_addrB(rd_addrB), .save(save), .restore(restore),
      .datA_out(a0), .datB_out(b0), .tap_a_out(ta0), .tap_b_out(tb0),
      .dirty(d0), .any_dirty(any0));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      reset = 0; wr_en = 0; save = 0; restore = 0;
   endtask

   task automatic wr(input logic [2:0] a, input logic [7:0] d);
      wr_en = 1; wr_addr = a; dat_in = d;
      tick();
      wr_en = 0;
   endtask

   initial begin
      reset = 1; wr_en = 0; save = 0; restore = 0;
      wr_addr = 0; dat_in = 0; rd_addrA = 0; rd_addrB = 0;
      tick();
      idle();
      for (int i = 0; i < 8; i++) begin
         rd_addrA = 3'(i); rd_addrB = 3'(7 - i);
         #1;
         chk("rst_a1", a1, 0); chk("rst_b1", b1, 0);
         chk("rst_a0", a0, 0); chk("rst_b0", b0, 0);
      end
      chk("rst_taps1", {ta1, tb1}, 0); chk("rst_taps0", {ta0, tb0}, 0);
      chk("rst_dirty1", {any1, d1}, 0); chk("rst_dirty0", {any0, d0}, 0);

      rd_addrA = 3;
      wr(3, 8'hA5);
      #1;
      chk("w3_a1", a1, 8'hA5); chk("w3_a0", a0, 8'hA5);
      chk("w3_dirty1", d1, 8'h08); chk("w3_any1", any1, 1);
      chk("w3_dirty0", d0, 8'h08); chk("w3_any0", any0, 1);

      wr_en = 1; wr_addr = 5; dat_in = 8'h3C; rd_addrA = 5; rd_addrB = 5;
      #1;
      chk("byp_a1", a1, 8'h3C); chk("byp_b1", b1, 8'h3C);
      chk("nobyp_a0", a0, 8'h00); chk("nobyp_b0", b0, 8'h00);
      tick();
      wr_en = 0;
      #1;
      chk("w5_a1", a1, 8'h3C); chk("w5_b0", b0, 8'h3C);
      chk("w5_dirty1", d1, 8'h28);

      wr(0, 8'h11);
      wr(1, 8'h22);
      save = 1; tick(); save = 0;
      #1;
      chk("save_dirty1", {any1, d1}, 0);
      wr(0, 8'h99);
      #1;
      chk("w0_tapa1", ta1, 8'h99); chk("w0_dirty1", d1, 8'h01);
      restore = 1; tick(); restore = 0;
      #1;
      chk("rst_tapa1", ta1, 8'h11); chk("rst_tapb1", tb1, 8'h22);
      chk("rst_tapa0", ta0, 8'h11); chk("rst_dirty1", {any1, d1}, 0);

      wr(2, 8'h10);
      save = 1; wr_en = 1; wr_addr = 2; dat_in = 8'h7E; rd_addrA = 2;
      tick();
      idle();
      #1;
      chk("sw_live2_1", a1, 8'h7E); chk("sw_live2_0", a0, 8'h7E);
      chk("sw_dirty1", d1, 8'h04); chk("sw_dirty0", d0, 8'h04);

      restore = 1; wr_en = 1; wr_addr = 4; dat_in = 8'h55; rd_addrA = 4; rd_addrB = 2;
      #1;
      chk("rw_nobyp_a1", a1, 8'h00);
      tick();
      idle();
      #1;
      chk("rw_r4_1", a1, 8'h00); chk("rw_r2_1", b1, 8'h10);
      chk("rw_r4_0", a0, 8'h00); chk("rw_r2_0", b0, 8'h10);
      chk("rw_dirty1", d1, 8'h00);

      wr(6, 8'hBB);
      save = 1; tick(); save = 0;
      wr(6, 8'hAA);
      rd_addrA = 6; rd_addrB = 7;
      save = 1; restore = 1; tick(); idle();
      #1;
      chk("swap1_r6_1", a1, 8'hBB); chk("swap1_r6_0", a0, 8'hBB);
      chk("swap1_dirty1", d1, 8'h00);
      wr(7, 8'h01);
      #1;
      chk("pre_swap2_dirty1", d1, 8'h80);
      save = 1; restore = 1; tick(); idle();
      #1;
      chk("swap2_r6_1", a1, 8'hAA); chk("swap2_r7_1", b1, 8'h00);
      chk("swap2_r6_0", a0, 8'hAA); chk("swap2_dirty1", {any1, d1}, 0);

      reset = 1; save = 1; wr_en = 1; wr_addr = 7; dat_in = 8'hFF; rd_addrA = 7; rd_addrB = 6;
      #1;
      chk("rstw_nobyp_a1", a1, 8'h00);
      tick();
      idle();
      #1;
      chk("rstw_r7_1", a1, 8'h00); chk("rstw_r6_1", b1, 8'h00);
      chk("rstw_dirty1", {any1, d1}, 0); chk("rstw_dirty0", {any0, d0}, 0);
      chk("rstw_taps1", {ta1, tb1}, 0);
      restore = 1; tick(); idle();
      #1;
      chk("rstw_rest_r7_1", a1, 8'h00); chk("rstw_rest_r6_1", b1, 8'h00);
      chk("rstw_rest_taps1", {ta1, tb1}, 0); chk("rstw_rest_r6_0", b0, 8'h00);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
